// File: rtl/wb_arbiter.sv
// wb_arbiter: register-file write-back arbiter; integer results always win, FP results queue in a FIFO
// and drain into free cycles, with a starvation hold request towards the integer pipeline.
module wb_arbiter #(
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     int_valid,
  input  logic [4:0]               int_reg,
  input  logic [31:0]              int_data,
  input  logic                     fp_valid,
  output logic                     fp_ready,
  input  logic [4:0]               fp_reg,
  input  logic                     fp_double,
  input  logic [31:0]              fp_data_lo,
  input  logic [31:0]              fp_data_hi,
  output logic                     wb_regWrite,
  output logic [4:0]               wb_writeReg,
  output logic [31:0]              wb_writeData,
  output logic                     wb_regWritef,
  output logic                     wb_regDWritef,
  output logic [4:0]               wb_writeRegf,
  output logic [31:0]              wb_writeData1f,
  output logic [31:0]              wb_writeData2f,
  output logic                     int_hold,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     proto_err
);
  localparam int AW = $clog2(DEPTH);
  localparam int WW = $clog2(STARVE_LIMIT + 1);

  typedef struct packed {
    logic [4:0]  r;
    logic        d;
    logic [31:0] lo;
    logic [31:0] hi;
  } ent_t;

  ent_t          mem [DEPTH];
  ent_t          head;
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0]   cnt_q, cnt_d;
  logic [WW-1:0] wait_q, wait_d;
  logic          hold_q, hold_d, perr_q;
  logic          rw_q, rwf_q, rdwf_q;
  logic [4:0]    wreg_q, wregf_q;
  logic [31:0]   wdat_q, d1_q, d2_q;
  logic          int_win, pop, push, drop;

  assign head     = mem[rd_q];
  assign fp_ready = cnt_q != (AW+1)'(DEPTH);
  // register 0 is hardwired; a double to 31 would spill past the file
  assign drop     = fp_reg == 5'd0 || (fp_double && fp_reg == 5'd31);
  assign push     = fp_valid && fp_ready && !drop;
  assign int_win  = int_valid && int_reg != 5'd0;
  assign pop      = !int_win && cnt_q != '0;

  always_comb begin
    cnt_d  = cnt_q + (AW+1)'(push) - (AW+1)'(pop);
    wait_d = (pop || cnt_q == '0) ? '0 : (wait_q == WW'(STARVE_LIMIT) ? wait_q : wait_q + WW'(1));
    hold_d = pop ? 1'b0 : (wait_q == WW'(STARVE_LIMIT) ? 1'b1 : hold_q);
  end

  always_ff @(posedge clk)
    if (push) mem[wr_q] <= '{r: fp_reg, d: fp_double, lo: fp_data_lo, hi: fp_data_hi};

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_q    <= '0;
      rd_q    <= '0;
      cnt_q   <= '0;
      wait_q  <= '0;
      hold_q  <= 1'b0;
      perr_q  <= 1'b0;
      rw_q    <= 1'b0;
      rwf_q   <= 1'b0;
      rdwf_q  <= 1'b0;
      wreg_q  <= '0;
      wregf_q <= '0;
      wdat_q  <= '0;
      d1_q    <= '0;
      d2_q    <= '0;
    end else begin
      wr_q   <= push ? wr_q + AW'(1) : wr_q;
      rd_q   <= pop ? rd_q + AW'(1) : rd_q;
      cnt_q  <= cnt_d;
      wait_q <= wait_d;
      hold_q <= hold_d;
      perr_q <= perr_q || (int_win && hold_q);
      rw_q   <= int_win;
      rwf_q  <= pop && !head.d;
      rdwf_q <= pop && head.d;
      if (int_win) begin
        wreg_q <= int_reg;
        wdat_q <= int_data;
      end else if (pop && !head.d) wreg_q <= head.r;
      if (pop) begin
        wregf_q <= head.r;
        d1_q    <= head.lo;
        if (head.d) d2_q <= head.hi;
      end
    end

  assign wb_regWrite    = rw_q;
  assign wb_writeReg    = wreg_q;
  assign wb_writeData   = wdat_q;
  assign wb_regWritef   = rwf_q;
  assign wb_regDWritef  = rdwf_q;
  assign wb_writeRegf   = wregf_q;
  assign wb_writeData1f = d1_q;
  assign wb_writeData2f = d2_q;
  assign int_hold       = hold_q;
  assign fifo_count     = cnt_q;
  assign proto_err      = perr_q;
endmodule

// File: tb/tb_wb_arbiter.sv
// tb_wb_arbiter: directed and random traffic checked against a queue-based model of the arbiter rules.
module tb_wb_arbiter;
  localparam int DEPTH = 4;
  localparam int LIMIT = 8;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic        int_valid = 1'b0, fp_valid = 1'b0, fp_double = 1'b0;
  logic [4:0]  int_reg = '0, fp_reg = '0;
  logic [31:0] int_data = '0, fp_data_lo = '0, fp_data_hi = '0;
  logic        fp_ready, wb_regWrite, wb_regWritef, wb_regDWritef, int_hold, proto_err;
  logic [4:0]  wb_writeReg, wb_writeRegf;
  logic [31:0] wb_writeData, wb_writeData1f, wb_writeData2f;
  logic [2:0]  fifo_count;

  wb_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst_n(rst_n), .int_valid(int_valid), .int_reg(int_reg), .int_data(int_data),
    .fp_valid(fp_valid), .fp_ready(fp_ready), .fp_reg(fp_reg), .fp_double(fp_double),
    .fp_data_lo(fp_data_lo), .fp_data_hi(fp_data_hi), .wb_regWrite(wb_regWrite),
    .wb_writeReg(wb_writeReg), .wb_writeData(wb_writeData), .wb_regWritef(wb_regWritef),
    .wb_regDWritef(wb_regDWritef), .wb_writeRegf(wb_writeRegf), .wb_writeData1f(wb_writeData1f),
    .wb_writeData2f(wb_writeData2f), .int_hold(int_hold), .fifo_count(fifo_count),
    .proto_err(proto_err));

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  r;
    logic        d;
    logic [31:0] lo;
    logic [31:0] hi;
  } ent_t;

  ent_t        q[$];
  int          cyc, head_since, npass, nfail;
  logic        e_rw, e_rwf, e_rdwf, e_hold, e_perr;
  logic [4:0]  e_wr, e_wrf;
  logic [31:0] e_wd, e_d1, e_d2;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    assert (obs === exp) npass++;
    else begin
      nfail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    cyc = 0; head_since = 0;
    {e_rw, e_rwf, e_rdwf, e_hold, e_perr} = '0;
    e_wr = '0; e_wrf = '0; e_wd = '0; e_d1 = '0; e_d2 = '0;
  endtask

  // one clock edge of the specified behaviour, evaluated with the inputs present before the edge
  task automatic model_edge();
    ent_t h;
    bit iw, pp, rdy;
    iw  = int_valid && int_reg != 0;
    rdy = q.size() != DEPTH;
    pp  = !iw && q.size() != 0;
    e_perr = e_perr || (iw && e_hold);
    e_rw = iw; e_rwf = 1'b0; e_rdwf = 1'b0;
    if (iw) begin
      e_wr = int_reg; e_wd = int_data;
    end else if (pp) begin
      h = q.pop_front();
      if (h.d) begin
        e_rdwf = 1'b1; e_d2 = h.hi;
      end else begin
        e_rwf = 1'b1; e_wr = h.r;
      end
      e_wrf = h.r; e_d1 = h.lo;
      head_since = cyc + 1;
    end
    if (fp_valid && rdy && !(fp_reg == 0 || (fp_double && fp_reg == 31))) begin
      if (q.size() == 0) head_since = cyc + 1;
      q.push_back('{r: fp_reg, d: fp_double, lo: fp_data_lo, hi: fp_data_hi});
    end
    cyc++;
    e_hold = q.size() != 0 && (cyc - head_since) >= LIMIT + 1;
  endtask

  task automatic check_all();
    chk("regWrite", 32'(wb_regWrite), 32'(e_rw));
    chk("regWritef", 32'(wb_regWritef), 32'(e_rwf));
    chk("regDWritef", 32'(wb_regDWritef), 32'(e_rdwf));
    chk("one_strobe", 32'(32'(wb_regWrite) + 32'(wb_regWritef) + 32'(wb_regDWritef) <= 1), 32'd1);
    chk("writeReg", 32'(wb_writeReg), 32'(e_wr));
    chk("writeData", wb_writeData, e_wd);
    chk("writeRegf", 32'(wb_writeRegf), 32'(e_wrf));
    chk("writeData1f", wb_writeData1f, e_d1);
    chk("writeData2f", wb_writeData2f, e_d2);
    chk("int_hold", 32'(int_hold), 32'(e_hold));
    chk("proto_err", 32'(proto_err), 32'(e_perr));
    chk("fifo_count", 32'(fifo_count), q.size());
    chk("fp_ready", 32'(fp_ready), 32'(q.size() != DEPTH));
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1 check_all();
  endtask

  task automatic idle();
    int_valid = 1'b0; fp_valid = 1'b0; int_reg = '0; fp_reg = '0; fp_double = 1'b0;
  endtask

  task automatic set_fp(input logic v, input logic [4:0] r, input logic d, input logic [31:0] lo,
                        input logic [31:0] hi);
    fp_valid = v; fp_reg = r; fp_double = d; fp_data_lo = lo; fp_data_hi = hi;
  endtask

  task automatic mid_reset();
    #2 rst_n = 1'b0;
    #1;
    chk("rst_strobes", 32'({wb_regWrite, wb_regWritef, wb_regDWritef, int_hold, proto_err}), 0);
    chk("rst_index", 32'({wb_writeReg, wb_writeRegf}), 0);
    chk("rst_data", wb_writeData | wb_writeData1f | wb_writeData2f, 0);
    chk("rst_count", 32'(fifo_count), 0);
    model_reset();
    idle();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1 chk("rst_ready", 32'(fp_ready), 1);
  endtask

  initial begin
    bit was_ready;
    int k;
    npass = 0; nfail = 0;
    model_reset();
    #12 check_all();
    @(negedge clk) rst_n = 1'b1;
    #1 chk("ready_after_rst", 32'(fp_ready), 1);
    int_valid = 1'b1; int_reg = 5'd5; int_data = 32'hDEADBEEF;
    step();
    chk("int_dead_reg", 32'(wb_writeReg), 5);
    chk("int_dead_data", wb_writeData, 32'hDEADBEEF);
    int_reg = 5'd0; int_data = 32'h12345678;
    step();
    chk("int_reg0", 32'(wb_regWrite), 0);
    idle();
    set_fp(1'b1, 5'd3, 1'b0, 32'h3F800000, 32'h0);
    step();
    fp_valid = 1'b0;
    step();
    chk("fp_single", 32'({wb_regWritef, wb_writeRegf, wb_writeReg}), 32'({1'b1, 5'd3, 5'd3}));
    set_fp(1'b1, 5'd6, 1'b1, 32'h11111111, 32'h22222222);
    step();
    fp_valid = 1'b0;
    step();
    chk("fp_double", 32'({wb_regDWritef, wb_writeRegf}), 32'({1'b1, 5'd6}));
    chk("fp_double_hi", wb_writeData2f, 32'h22222222);
    set_fp(1'b1, 5'd31, 1'b1, 32'hA, 32'hB);
    step();
    fp_reg = 5'd0;
    step();
    fp_valid = 1'b0;
    step();
    step();
    chk("drop_31_0", 32'(wb_regDWritef), 0);
    // contention: integer writes every cycle while five FP results are offered
    int_valid = 1'b1; int_reg = 5'd7;
    k = 0;
    for (int i = 0; i < 16; i++) begin
      int_data = $urandom;
      set_fp(1'b1, 5'(k + 8), k[0], 32'(100 + k), 32'(200 + k));
      was_ready = fp_ready;
      step();
      if (was_ready && k < 4) k++;
      if (i == 5) begin
        chk("full_count", 32'(fifo_count), 4);
        chk("full_ready", 32'(fp_ready), 0);
      end
    end
    chk("hold_raised", 32'(int_hold), 1);
    chk("proto_set", 32'(proto_err), 1);
    idle();
    repeat (8) step();
    chk("proto_sticky", 32'(proto_err), 1);
    chk("drained", 32'(fifo_count), 0);
    mid_reset();
    for (int i = 0; i < 400; i++) begin
      int_valid = e_hold ? ($urandom_range(15) == 0) : ($urandom_range(2) != 0);
      int_reg = ($urandom_range(7) == 0) ? 5'd0 : 5'($urandom);
      int_data = $urandom;
      set_fp(1'($urandom), 5'($urandom), 1'($urandom), $urandom, $urandom);
      step();
      if (i == 200) mid_reset();
    end
    $display("%0d/%0d checks passed", npass, npass + nfail);
    $finish;
  end
endmodule
